// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode enum and pointer/count width helpers.
package fifo_pkg;

  typedef enum logic {
    FIFO_REG  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Storage address width for a power-of-two depth.
  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Pointer and count width: address bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// FIFO control: read/write pointers, occupancy count, status flags and
// sticky overflow/underflow error flags.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_req,
  input  logic                       read_req,
  input  logic                       clr_err,
  output logic                       wr_acc_c,
  output logic                       rd_acc_c,
  output logic [addr_w(DEPTH)-1:0]   waddr,
  output logic [addr_w(DEPTH)-1:0]   raddr,
  output logic [ptr_w(DEPTH)-1:0]    count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = addr_w(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ae_q, ae_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  // Acceptance uses pre-edge flags; flags are recomputed from the next count.
  always_comb begin
    wr_acc_c = write_req & ~full_q;
    rd_acc_c = read_req & ~empty_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    if (wr_acc_c) wptr_d = wptr_q + PW'(1);
    if (rd_acc_c) rptr_d = rptr_q + PW'(1);
    count_d  = count_q + PW'(wr_acc_c) - PW'(rd_acc_c);
    empty_d  = (count_d == '0);
    full_d   = (count_d == PW'(DEPTH));
    ae_d     = (count_d <= PW'(AE_LEVEL));
    af_d     = (count_d >= PW'(AF_LEVEL));
    // A new error event outranks a coincident clear.
    ovf_d    = (write_req & full_q) | (ovf_q & ~clr_err);
    unf_d    = (read_req & empty_q) | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign waddr        = wptr_q[AW-1:0];
  assign raddr        = rptr_q[AW-1:0];
  assign count        = count_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with registered-read or first-word-fall-through
// output, full-depth capacity and sticky error flags.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned FWFT     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      writeEn,
  input  logic                      readEn,
  input  logic [DWIDTH-1:0]         dataIn,
  input  logic                      clrErr,
  output logic [DWIDTH-1:0]         dataOut,
  output logic [ptr_w(DEPTH)-1:0]   count,
  output logic                      EMPTY,
  output logic                      FULL,
  output logic                      ALMOST_EMPTY,
  output logic                      ALMOST_FULL,
  output logic                      OVERFLOW,
  output logic                      UNDERFLOW
);

  localparam int unsigned AW   = addr_w(DEPTH);
  localparam fifo_mode_e  MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("param_fifo: DEPTH must be a power of two and at least 2");
  end

  logic          wr_acc;
  logic          rd_acc;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [DWIDTH-1:0] mem_q [DEPTH];

  fifo_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .write_req    (writeEn),
    .read_req     (readEn),
    .clr_err      (clrErr),
    .wr_acc_c     (wr_acc),
    .rd_acc_c     (rd_acc),
    .waddr        (waddr),
    .raddr        (raddr),
    .count        (count),
    .empty        (EMPTY),
    .full         (FULL),
    .almost_empty (ALMOST_EMPTY),
    .almost_full  (ALMOST_FULL),
    .overflow     (OVERFLOW),
    .underflow    (UNDERFLOW)
  );

  // Storage is never reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem_q[waddr] <= dataIn;
  end

  if (MODE == FIFO_REG) begin : g_reg
    logic [DWIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_acc) dout_d = mem_q[raddr];
    end

    always_ff @(posedge clk) begin
      if (reset) dout_q <= '0;
      else       dout_q <= dout_d;
    end

    assign dataOut = dout_q;
  end else begin : g_fwft
    // Head entry is visible as soon as it is written and the count updates.
    assign dataOut = mem_q[raddr];
  end

endmodule
